// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the shaping-filter datapath and its downstream
// peak detector: sample widths, the filter output sample type and the
// peak-detector state encoding.
// -----------------------------------------------------------------------------
package filter_pkg;

   localparam int SIZE_ADC_DATA    = 14;
   localparam int SIZE_FILTER_DATA = 16;
   // The shaping filter grows the sample by four guard bits.
   localparam int FILTER_OUT_W     = SIZE_FILTER_DATA + 4;

   typedef logic signed [FILTER_OUT_W-1:0] filter_sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      EMIT = 2'd2,
      DEAD = 2'd3
   } pd_state_t;

endpackage

// File: rtl/pd_timestamp.sv
// -----------------------------------------------------------------------------
// pd_timestamp
// Free-running timestamp counter, +1 every clock, silently wrapping modulo
// 2^TS_W. Kept separate so several detector channels can share one time base.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears the count
//   ts    - current timestamp
// -----------------------------------------------------------------------------
module pd_timestamp #(
   parameter int TS_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [TS_W-1:0] ts
);

   // Wrapping timestamp counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts <= {TS_W{1'b0}};
      end else begin
         ts <= ts + {{(TS_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/filter_peak_detector.sv
// -----------------------------------------------------------------------------
// filter_peak_detector
// Finds pulses in the signed filter stream that rise strictly above a
// threshold, reports the peak amplitude and its timestamp through a one-cycle
// strobe, then holds off for a programmable dead time. Crossings seen during
// the dead time flag pile-up on the next event; pulses longer than MAX_WIDTH
// samples are cut short and flagged overlong.
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-low reset
//   filter_data    - signed filter sample, one per clock
//   threshold      - signed trigger level (quasi-static)
//   dead_time      - hold-off cycles after each event (quasi-static)
//   peak_valid     - one-cycle strobe for a completed event
//   peak_amplitude - maximum sample of the event (held until next event)
//   peak_time      - timestamp of the first maximum sample (held)
//   pileup         - event preceded by a crossing in the previous dead time
//   overlong       - event aborted at MAX_WIDTH samples
//   busy           - detector is not idle
// -----------------------------------------------------------------------------
module filter_peak_detector
   import filter_pkg::*;
#(
   parameter int DATA_W    = FILTER_OUT_W,
   parameter int TS_W      = 32,
   parameter int DT_W      = 8,
   parameter int MAX_WIDTH = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] filter_data,
   input  logic signed [DATA_W-1:0] threshold,
   input  logic        [DT_W-1:0]   dead_time,
   output logic                     peak_valid,
   output logic signed [DATA_W-1:0] peak_amplitude,
   output logic        [TS_W-1:0]   peak_time,
   output logic                     pileup,
   output logic                     overlong,
   output logic                     busy
);

   localparam int                WC_W     = $clog2(MAX_WIDTH + 1);
   localparam logic [WC_W-1:0]   WC_ONE   = {{(WC_W-1){1'b0}}, 1'b1};
   localparam logic [WC_W-1:0]   WC_LIMIT = WC_W'(MAX_WIDTH);
   localparam logic [DT_W-1:0]   DT_ONE   = {{(DT_W-1){1'b0}}, 1'b1};
   localparam logic [DT_W-1:0]   DT_ZERO  = {DT_W{1'b0}};

   pd_state_t                 state_r;
   pd_state_t                 next_state_s;
   logic signed [DATA_W-1:0]  max_r;
   logic        [TS_W-1:0]    max_ts_r;
   logic        [WC_W-1:0]    width_r;
   logic        [DT_W-1:0]    dt_r;
   logic                      pend_pile_r;
   logic                      over_pend_r;
   logic signed [DATA_W-1:0]  prev_r;
   logic        [TS_W-1:0]    ts_s;

   logic                      above_s;
   logic                      prev_above_s;
   logic                      new_max_s;
   logic                      over_hit_s;
   logic                      valid_nxt_s;
   logic                      busy_nxt_s;
   logic                      capture_s;
   logic signed [DATA_W-1:0]  cand_amp_s;
   logic        [TS_W-1:0]    cand_ts_s;

   pd_timestamp #(.TS_W(TS_W)) u_ts (
      .clk   (clk),
      .rst_n (reset),
      .ts    (ts_s)
   );

   // Strict signed comparisons: equality with the threshold or with the
   // running maximum never counts, so a flat top keeps its earliest sample.
   assign above_s      = $signed(filter_data) > $signed(threshold);
   assign prev_above_s = $signed(prev_r) > $signed(threshold);
   assign new_max_s    = $signed(filter_data) > $signed(max_r);
   assign over_hit_s   = above_s && (width_r == WC_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (above_s) next_state_s = RISE;
            else         next_state_s = IDLE;
         end
         RISE: begin
            if (!above_s || over_hit_s) next_state_s = EMIT;
            else                        next_state_s = RISE;
         end
         EMIT: begin
            if (dead_time == DT_ZERO) next_state_s = IDLE;
            else                      next_state_s = DEAD;
         end
         DEAD: begin
            // A zero count cannot occur here; treat it as expired.
            if (dt_r <= DT_ONE) next_state_s = IDLE;
            else                next_state_s = DEAD;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode: registered strobe/busy follow the next state, and the
   // event result is captured on the RISE->EMIT transition including the
   // sample arriving in that same cycle.
   always_comb begin
      valid_nxt_s = (next_state_s == EMIT);
      busy_nxt_s  = (next_state_s != IDLE);
      capture_s   = (state_r == RISE) && (next_state_s == EMIT);
      cand_amp_s  = new_max_s ? filter_data : max_r;
      cand_ts_s   = new_max_s ? ts_s : max_ts_r;
   end

   // Pulse tracking, dead-time bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_r          <= {DATA_W{1'b0}};
         max_ts_r       <= {TS_W{1'b0}};
         width_r        <= {WC_W{1'b0}};
         dt_r           <= DT_ZERO;
         pend_pile_r    <= 1'b0;
         over_pend_r    <= 1'b0;
         prev_r         <= {DATA_W{1'b0}};
         peak_valid     <= 1'b0;
         busy           <= 1'b0;
         peak_amplitude <= {DATA_W{1'b0}};
         peak_time      <= {TS_W{1'b0}};
         pileup         <= 1'b0;
         overlong       <= 1'b0;
      end else begin
         prev_r     <= filter_data;
         peak_valid <= valid_nxt_s;
         busy       <= busy_nxt_s;
         case (state_r)
            IDLE: begin
               if (above_s) begin
                  max_r    <= filter_data;
                  max_ts_r <= ts_s;
                  width_r  <= WC_ONE;
               end
            end
            RISE: begin
               width_r <= width_r + WC_ONE;
               if (new_max_s) begin
                  max_r    <= filter_data;
                  max_ts_r <= ts_s;
               end
               if (over_hit_s) begin
                  over_pend_r <= 1'b1;
               end
               if (capture_s) begin
                  peak_amplitude <= cand_amp_s;
                  peak_time      <= cand_ts_s;
                  pileup         <= pend_pile_r;
                  overlong       <= over_pend_r | over_hit_s;
               end
            end
            EMIT: begin
               pend_pile_r <= 1'b0;
               over_pend_r <= 1'b0;
               dt_r        <= dead_time;
            end
            DEAD: begin
               dt_r <= dt_r - DT_ONE;
               // Only a fresh rising crossing marks pile-up, not a level.
               if (above_s && !prev_above_s) begin
                  pend_pile_r <= 1'b1;
               end
            end
            default: begin
               dt_r <= DT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: doc/filter_peak_detector.md
Name: filter_peak_detector

Overview:
- Sits directly downstream of the shaping filter and consumes its signed output stream.
- Detects pulses whose filtered amplitude exceeds a programmable threshold, then reports the peak amplitude and the peak timestamp.
- Applies a programmable dead time after each event and flags pile-up or over-long pulses.
- Feeds the event readout/histogram logic through a one-cycle valid strobe.

Parameters:
- DATA_W, SIZE_FILTER_DATA+4 — width of the signed filter sample.
- TS_W, 32 — timestamp counter width.
- DT_W, 8 — dead-time counter width.
- MAX_WIDTH, 255 — maximum allowed pulse width in samples before the pulse is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- filter_data  in  DATA_W  signed filter output, one sample per clk.
- threshold  in  DATA_W  signed trigger level; quasi-static.
- dead_time  in  DT_W  hold-off cycles after each event; quasi-static.
- peak_valid  out  1  one-cycle strobe for a completed event.
- peak_amplitude  out  DATA_W  signed maximum sample of the event.
- peak_time  out  TS_W  timestamp of the maximum sample.
- pileup  out  1  qualifies peak_valid: a second crossing occurred during dead time.
- overlong  out  1  qualifies peak_valid: the pulse exceeded MAX_WIDTH.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; FSM goes to IDLE.
  - ts, max_reg, max_ts, width_cnt, dt_cnt and the pending_pileup flag are cleared.
  - Reset mid-pulse discards the event; no strobe is emitted.
- Timestamp ts: free-running, +1 every clk, wraps modulo 2^TS_W with no flag.
- All comparisons are signed ($signed) at full DATA_W width; a sample equal to threshold does not trigger.
- FSM states: IDLE, RISE, EMIT, DEAD.
  - IDLE:
    - If filter_data > threshold: go to RISE; max_reg<=filter_data; max_ts<=ts; width_cnt<=1.
  - RISE:
    - If filter_data > max_reg: update max_reg and max_ts. On equality, keep the first (earliest) maximum.
    - width_cnt increments every cycle.
    - If filter_data <= threshold: go to EMIT.
    - Else if width_cnt == MAX_WIDTH: set overlong_pend and go to EMIT.
  - EMIT (exactly 1 cycle):
    - peak_valid=1.
    - peak_amplitude, peak_time, pileup, overlong are driven from registers; pileup reports the pending_pileup flag set by a crossing during the previous event's dead time.
    - pending_pileup and overlong_pend are then cleared.
    - Load dt_cnt<=dead_time and go to DEAD; if dead_time==0, go directly to IDLE.
  - DEAD:
    - dt_cnt decrements each cycle; when dt_cnt==1, go to IDLE.
    - A rising crossing (previous sample <= threshold, current sample > threshold) sets pending_pileup. That flag is reported with the next emitted event.
    - Samples during DEAD never start an event.
- Overlong exit: the next IDLE is entered through DEAD. If the signal is still above threshold, IDLE retriggers on the following sample.
- Latency: peak_valid rises on the edge after the first sample <= threshold is sampled in RISE, i.e. 1 clk after the falling crossing.
- Output hold:
  - peak_amplitude, peak_time, pileup and overlong hold their values until the next EMIT.
  - peak_valid is high only in EMIT.
- No back-pressure: the consumer must accept every strobe. The minimum event spacing is 3 clk.

Decomposition:
- Shared package filter_pkg holds:
  - SIZE_ADC_DATA, SIZE_FILTER_DATA, and the derived FILTER_OUT_W = SIZE_FILTER_DATA+4;
  - typedef filter_sample_t (signed [FILTER_OUT_W-1:0]);
  - the enum typedef pd_state_t {IDLE, RISE, EMIT, DEAD}.
- One natural sub-module: pd_timestamp, the free-running wrapping counter, so it can be shared with other channels.
- Everything else stays in one always_ff block plus next-state logic.

Test Plan:
- Single triangular pulse, threshold=100: samples 0,50,150,300,420,310,90,0 with ts starting at 0 -> one strobe 1 clk after the sample 90; peak_amplitude=420, peak_time=4, pileup=0, overlong=0.
- Negative baseline, threshold=-10: samples -50,-20,-10 -> no trigger (the equality case). Then sample -9 -> trigger, and a strobe follows on the return to <= -10.
- Two pulses 4 clk apart with dead_time=10 -> exactly one strobe. The next event emitted after DEAD reports pileup=1; the following event reports pileup=0.
- Constant 500 with threshold=100 and MAX_WIDTH=255 -> strobe 1 clk after width_cnt reaches 255 with overlong=1 and peak_amplitude=500; after DEAD ends, retrigger happens on the next sample.
- Flat-top peak 200,300,300,300,50 -> peak_time equals the ts of the first 300.
- reset pulsed low in the middle of RISE -> no strobe, all outputs 0, ts restarts at 0. A clean pulse afterwards reports correctly.
- Timestamp wrap with TS_W=4: pulse maximum at ts=15, falling crossing at ts=1 -> peak_time=15.
